// File: rtl/mips_defs.sv
// Shared MIPS decode constants: opcodes, funct codes, forward-select encodings and reset PC.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_M   = 2'd1;
  localparam logic [1:0] FWD_E   = 2'd2;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // Branch target relative to the delay-slot PC; wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] add4, input logic [15:0] imm);
    return add4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/id_stage_grf.sv
// 32x32 general register file: synchronous clear, hardwired $0, write-through bypass on reads.
module grf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [4:0]  i_a1,
  input  logic [4:0]  i_a2,
  input  logic [4:0]  i_a3,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] r_regs [32];
  logic        w_wr;

  assign w_wr = i_we && (i_a3 != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'h0;
      end
    end else if (w_wr) begin
      r_regs[i_a3] <= i_wd;
    end
  end

  function automatic logic [31:0] rd(input logic [4:0] addr, input logic [31:0] arr_val);
    if (addr == 5'd0) begin
      return 32'h0;
    end else if (w_wr && (i_a3 == addr)) begin
      return i_wd;
    end
    return arr_val;
  endfunction

  assign o_rd1 = rd(i_a1, r_regs[i_a1]);
  assign o_rd2 = rd(i_a2, r_regs[i_a2]);

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, GRF, operand forwarding and early branch/jump resolution.
module id_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC_ADD4 = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IM,
  input  logic [31:0] ADD4,
  input  logic [31:0] ADD8,
  input  logic        ID_en,
  input  logic [1:0]  Fwd_rs_D,
  input  logic [1:0]  Fwd_rt_D,
  input  logic [31:0] FwdData_E,
  input  logic [31:0] FwdData_M,
  input  logic        RegWrite_W,
  input  logic [4:0]  A3_W,
  input  logic [31:0] WD_W,
  output logic [31:0] Instr_D,
  output logic [31:0] ADD8_D,
  output logic [31:0] RD1_D,
  output logic [31:0] RD2_D,
  output logic [31:0] NPC,
  output logic        j_D,
  output logic        jr_D,
  output logic        PCSrc_D
);

  logic [31:0] r_instr;
  logic [31:0] r_add4;
  logic [31:0] r_add8;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= 32'h0;
      r_add4  <= RESET_PC_ADD4;
      r_add8  <= RESET_PC_ADD4;
    end else if (ID_en) begin
      r_instr <= IM;
      r_add4  <= ADD4;
      r_add8  <= ADD8;
    end
  end

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [31:0] w_grf_rd1;
  logic [31:0] w_grf_rd2;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  assign w_op    = r_instr[31:26];
  assign w_funct = r_instr[5:0];
  assign w_rs    = r_instr[25:21];
  assign w_rt    = r_instr[20:16];

  grf u_grf (
    .clk   (clk),
    .reset (reset),
    .i_we  (RegWrite_W),
    .i_a1  (w_rs),
    .i_a2  (w_rt),
    .i_a3  (A3_W),
    .i_wd  (WD_W),
    .o_rd1 (w_grf_rd1),
    .o_rd2 (w_grf_rd2)
  );

  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] grf_val,
                                          input logic [31:0] m_val, input logic [31:0] e_val);
    case (sel)
      FWD_M:   return m_val;
      FWD_E:   return e_val;
      default: return grf_val;
    endcase
  endfunction

  assign w_rd1 = fwd_mux(Fwd_rs_D, w_grf_rd1, FwdData_M, FwdData_E);
  assign w_rd2 = fwd_mux(Fwd_rt_D, w_grf_rd2, FwdData_M, FwdData_E);

  logic [31:0] w_npc;
  logic        w_j;
  logic        w_jr;
  logic        w_pcsrc;

  // Non-redirecting instructions still drive NPC to ADD8_D so the value is deterministic.
  always_comb begin
    w_npc   = r_add8;
    w_j     = 1'b0;
    w_jr    = 1'b0;
    w_pcsrc = 1'b0;
    case (w_op)
      OP_BEQ: begin
        w_pcsrc = (w_rd1 == w_rd2);
        w_npc   = branch_target(r_add4, r_instr[15:0]);
      end
      OP_BNE: begin
        w_pcsrc = (w_rd1 != w_rd2);
        w_npc   = branch_target(r_add4, r_instr[15:0]);
      end
      OP_J, OP_JAL: begin
        w_j   = 1'b1;
        w_npc = {r_add4[31:28], r_instr[25:0], 2'b00};
      end
      OP_RTYPE: begin
        if (w_funct == FN_JR) begin
          w_jr  = 1'b1;
          w_npc = w_rd1;
        end
      end
      default: ;
    endcase
  end

  assign Instr_D = r_instr;
  assign ADD8_D  = r_add8;
  assign RD1_D   = w_rd1;
  assign RD2_D   = w_rd2;
  assign NPC     = w_npc;
  assign j_D     = w_j;
  assign jr_D    = w_jr;
  assign PCSrc_D = w_pcsrc;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: per-cycle stimulus table plus a reset-mid-branch sequence.
module tb_id_stage;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IM, ADD4, ADD8;
  logic        ID_en;
  logic [1:0]  Fwd_rs_D, Fwd_rt_D;
  logic [31:0] FwdData_E, FwdData_M;
  logic        RegWrite_W;
  logic [4:0]  A3_W;
  logic [31:0] WD_W;
  logic [31:0] Instr_D, ADD8_D, RD1_D, RD2_D, NPC;
  logic        j_D, jr_D, PCSrc_D;

  localparam logic [31:0] RstAdd4 = RESET_PC + 32'd4;

  id_stage #(.RESET_PC_ADD4(RstAdd4)) dut (
    .clk        (clk),
    .reset      (reset),
    .IM         (IM),
    .ADD4       (ADD4),
    .ADD8       (ADD8),
    .ID_en      (ID_en),
    .Fwd_rs_D   (Fwd_rs_D),
    .Fwd_rt_D   (Fwd_rt_D),
    .FwdData_E  (FwdData_E),
    .FwdData_M  (FwdData_M),
    .RegWrite_W (RegWrite_W),
    .A3_W       (A3_W),
    .WD_W       (WD_W),
    .Instr_D    (Instr_D),
    .ADD8_D     (ADD8_D),
    .RD1_D      (RD1_D),
    .RD2_D      (RD2_D),
    .NPC        (NPC),
    .j_D        (j_D),
    .jr_D       (jr_D),
    .PCSrc_D    (PCSrc_D)
  );

  always #5 clk = ~clk;

  // Inputs are applied just after a falling edge; expectations describe the outputs in that
  // same cycle (before the next rising edge commits the row).
  typedef struct packed {
    logic [31:0] im;
    logic [31:0] add4;
    logic        en;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic [31:0] fe;
    logic [31:0] fm;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] x_instr;
    logic [31:0] x_add8;
    logic [31:0] x_rd1;
    logic [31:0] x_rd2;
    logic [31:0] x_npc;
    logic        x_j;
    logic        x_jr;
    logic        x_pc;
  } vec_t;

  localparam int NVec = 12;
  vec_t vecs [NVec];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%08h expected=%08h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("Instr_D", idx, Instr_D, v.x_instr);
    chk("ADD8_D",  idx, ADD8_D,  v.x_add8);
    chk("RD1_D",   idx, RD1_D,   v.x_rd1);
    chk("RD2_D",   idx, RD2_D,   v.x_rd2);
    chk("NPC",     idx, NPC,     v.x_npc);
    chk("j_D",     idx, {31'b0, j_D},     {31'b0, v.x_j});
    chk("jr_D",    idx, {31'b0, jr_D},    {31'b0, v.x_jr});
    chk("PCSrc_D", idx, {31'b0, PCSrc_D}, {31'b0, v.x_pc});
  endtask

  initial begin
    //          im            add4      en frs frt fe  fm  we a3  wd
    //          instr         add8d     rd1       rd2   npc       j jr pc
    // j 0x0C05 loaded; reset state visible
    vecs[0]  = '{32'h0800_0C05, 32'h3004, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                 32'h0, 32'h3004, 32'd0, 32'd0, 32'h3004, 1'b0, 1'b0, 1'b0};
    // j in D; write $8=5; load beq $8,$9,-1
    vecs[1]  = '{32'h1109_FFFF, 32'h3010, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 5'd8, 32'd5,
                 32'h0800_0C05, 32'h3008, 32'd0, 32'd0, 32'h3014, 1'b1, 1'b0, 1'b0};
    // beq in D, $9 via bypass; load bne $8,$9,-1
    vecs[2]  = '{32'h1509_FFFF, 32'h3010, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 5'd9, 32'd5,
                 32'h1109_FFFF, 32'h3014, 32'd5, 32'd5, 32'h300C, 1'b0, 1'b0, 1'b1};
    // bne not taken; load jr $31
    vecs[3]  = '{32'h03E0_0008, 32'h3018, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                 32'h1509_FFFF, 32'h3014, 32'd5, 32'd5, 32'h300C, 1'b0, 1'b0, 1'b0};
    // jr $31 with same-cycle write of $31; load beq $1,$2,4
    vecs[4]  = '{32'h1022_0004, 32'h3020, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 5'd31, 32'h3008,
                 32'h03E0_0008, 32'h301C, 32'h3008, 32'd0, 32'h3008, 1'b0, 1'b1, 1'b0};
    // beq forwarded E/M equal; stall starts
    vecs[5]  = '{32'hAAAA_5555, 32'h4000, 1'b0, 2'd2, 2'd1, 32'd7, 32'd7, 1'b0, 5'd0, 32'd0,
                 32'h1022_0004, 32'h3024, 32'd7, 32'd7, 32'h3030, 1'b0, 1'b0, 1'b1};
    // stalled, M data changes -> not taken
    vecs[6]  = '{32'hFFFF_FFFF, 32'hDEAD_0000, 1'b0, 2'd2, 2'd1, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0,
                 32'h1022_0004, 32'h3024, 32'd7, 32'd8, 32'h3030, 1'b0, 1'b0, 1'b0};
    // stalled, sel 3 / 0 both read GRF (zeros)
    vecs[7]  = '{32'h1234_5678, 32'h5000, 1'b0, 2'd3, 2'd0, 32'd7, 32'd8, 1'b1, 5'd0, 32'hFFFF_FFFF,
                 32'h1022_0004, 32'h3024, 32'd0, 32'd0, 32'h3030, 1'b0, 1'b0, 1'b1};
    // stall released; load jr $0 while writing $0
    vecs[8]  = '{32'h0000_0008, 32'h3034, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF,
                 32'h1022_0004, 32'h3024, 32'd0, 32'd0, 32'h3030, 1'b0, 1'b0, 1'b1};
    // jr $0 reads 0 despite $0 write; load beq $3,$0,2
    vecs[9]  = '{32'h1060_0002, 32'h3040, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF,
                 32'h0000_0008, 32'h3038, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0};
    // beq $3 with bypassed write $3=9; hold
    vecs[10] = '{32'h0, 32'h6000, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 5'd3, 32'd9,
                 32'h1060_0002, 32'h3044, 32'd9, 32'd0, 32'h3048, 1'b0, 1'b0, 1'b0};
    // $3 now from the array
    vecs[11] = '{32'h0, 32'h6000, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                 32'h1060_0002, 32'h3044, 32'd9, 32'd0, 32'h3048, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; IM = '0; ADD4 = '0; ADD8 = '0; ID_en = 1'b0;
    Fwd_rs_D = FWD_GRF; Fwd_rt_D = FWD_GRF; FwdData_E = '0; FwdData_M = '0;
    RegWrite_W = 1'b0; A3_W = '0; WD_W = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      IM = vecs[i].im; ADD4 = vecs[i].add4; ADD8 = vecs[i].add4 + 32'd4; ID_en = vecs[i].en;
      Fwd_rs_D = vecs[i].frs; Fwd_rt_D = vecs[i].frt;
      FwdData_E = vecs[i].fe; FwdData_M = vecs[i].fm;
      RegWrite_W = vecs[i].we; A3_W = vecs[i].a3; WD_W = vecs[i].wd;
      #1;
      chk_all(i, vecs[i]);
    end

    // Reset mid-branch with a simultaneous write to $5 and ID_en high: reset wins.
    @(negedge clk);
    reset = 1'b1; ID_en = 1'b1; IM = 32'h1234_5678; ADD4 = 32'h7000; ADD8 = 32'h7004;
    RegWrite_W = 1'b1; A3_W = 5'd5; WD_W = 32'h55;
    @(negedge clk);
    reset = 1'b0; ID_en = 1'b0; RegWrite_W = 1'b0; A3_W = '0; WD_W = '0;
    #1;
    chk("rst Instr_D", 100, Instr_D, 32'h0);
    chk("rst ADD8_D",  100, ADD8_D, RstAdd4);
    chk("rst NPC",     100, NPC, RstAdd4);
    chk("rst quals",   100, {29'b0, j_D, jr_D, PCSrc_D}, 32'h0);

    // beq $3,$5 after reset: both read 0, so taken
    IM = 32'h1065_0000; ADD4 = 32'h3100; ADD8 = 32'h3104; ID_en = 1'b1;
    @(negedge clk);
    ID_en = 1'b0;
    #1;
    chk("post Instr_D", 101, Instr_D, 32'h1065_0000);
    chk("post rd \$3",  101, RD1_D, 32'h0);
    chk("post rd \$5",  101, RD2_D, 32'h0);
    chk("post PCSrc",   101, {31'b0, PCSrc_D}, 32'h1);
    chk("post NPC",     101, NPC, 32'h3100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the five-stage MIPS pipeline, directly downstream of the fetch stage. It holds the IF/ID pipeline register, the 32×32 general register file with write-through bypass, and the early branch/jump resolution logic. It returns `NPC`, `j_D`, `jr_D` and `PCSrc_D` to fetch in the same cycle, and hands the decoded operands to the execute stage. Branches resolve in D with one architectural delay slot, so no flush is needed.

## Interface
Parameters:
- `RESET_PC_ADD4` (default `32'h0`): reset value of the latched `ADD4_D`/`ADD8_D`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `IM`  in  32  instruction from fetch.
- `ADD4`, `ADD8`  in  32  fetch PC+4 / PC+8.
- `ID_en`  in  1  IF/ID register load enable (0 = stall, hold).
- `Fwd_rs_D`, `Fwd_rt_D`  in  2  operand select: 0 = GRF, 1 = `FwdData_M`, 2 = `FwdData_E`, 3 = GRF.
- `FwdData_E`, `FwdData_M`  in  32  forwarded results.
- `RegWrite_W`  in  1  GRF write enable.
- `A3_W`  in  5  write address.
- `WD_W`  in  32  write data.
- `Instr_D`  out  32  latched instruction.
- `ADD8_D`  out  32  latched PC+8 (jal link value).
- `RD1_D`, `RD2_D`  out  32  forwarded rs/rt values.
- `NPC`  out  32  redirect target.
- `j_D`, `jr_D`, `PCSrc_D`  out  1  redirect qualifiers.

## Operation
- IF/ID register: on reset, `Instr_D` = 0 (nop) and `ADD4_D` = `ADD8_D` = `RESET_PC_ADD4`. Otherwise it loads `IM`/`ADD4`/`ADD8` when `ID_en`=1 and holds when `ID_en`=0. Reset dominates `ID_en`.
- GRF: 32 registers, all cleared on reset.
  - A write occurs at the rising edge when `RegWrite_W`=1 and `A3_W`≠0. Writes to `$0` are ignored, and `$0` always reads 0.
  - Reads are combinational on `rs`=`Instr_D[25:21]` and `rt`=`Instr_D[20:16]`.
  - Write-through bypass: if `RegWrite_W` && `A3_W`≠0 && `A3_W`==addr, the read returns `WD_W`.
- Forward mux: applied to the GRF output per `Fwd_*_D`; the result drives `RD1_D`/`RD2_D` and the comparator.
- Decode (op = `Instr_D[31:26]`, funct = `[5:0]`):
  - beq op 000100: `PCSrc_D` = (`RD1_D`==`RD2_D`), `NPC` = `ADD4_D` + (sext(imm16) << 2).
  - bne op 000101: `PCSrc_D` = (`RD1_D`≠`RD2_D`), same target.
  - j op 000010 / jal op 000011: `j_D`=1, `NPC` = {`ADD4_D[31:28]`, `Instr_D[25:0]`, 2'b00}.
  - jr op 000000 funct 001000: `jr_D`=1, `NPC` = `RD1_D`.
  - Any other instruction: all qualifiers are 0 and `NPC` = `ADD8_D` (deterministic don't-care).
- At most one qualifier is high in any cycle.
- Arithmetic is 32-bit modulo 2^32; the branch target wraps silently.

## Timing
- IF/ID register latency is 1 cycle: `IM` at edge k appears on `Instr_D` after edge k.
- `NPC` and the qualifiers are combinational from `Instr_D`, the GRF and the forward inputs, valid within the same cycle. Fetch consumes them at the next edge.
- A GRF write at edge k is visible in the same cycle through the bypass, and from the array after edge k.
- Stall with a branch in D: the qualifiers stay asserted every stalled cycle and must track forward-data changes. Fetch is also stalled by the hazard unit.
- Simultaneous reset and write: reset wins, and the register reads 0 after the edge.
- Reset mid-operation: the next cycle shows a nop in D, all qualifiers 0, and all GRF entries 0.

## Structure
- Shared package `mips_defs`: opcode/funct constants (`OP_BEQ`, `OP_BNE`, `OP_J`, `OP_JAL`, `OP_RTYPE`, `FN_JR`), forward-select encodings (`FWD_GRF`, `FWD_M`, `FWD_E`), and the reset PC `32'h00003000`.
- Sub-module `grf`: array, reset clear, `$0` rule and write-through bypass.
- `id_stage` contains the IF/ID register, forward muxes, comparator and NPC logic.

## Test plan
- Reset, then `IM`=`32'h0800_0C05` (j), `ADD4`=`32'h3004`, `ID_en`=1, one edge → `j_D`=1, `NPC`=`32'h0000_3014`.
- Write `$8`=5 and `$9`=5 via W, then beq `$8`,`$9`,imm=`16'hFFFF` with `ADD4_D`=`32'h3010` → `PCSrc_D`=1, `NPC`=`32'h300C`. With bne instead → `PCSrc_D`=0.
- Same-cycle bypass: `RegWrite_W`=1, `A3_W`=31, `WD_W`=`32'h3008`, jr `$31` in D → `jr_D`=1, `NPC`=`32'h3008` in that cycle.
- Forwarding: beq `$1`,`$2` with GRF `$1`=0, `Fwd_rs_D`=2, `FwdData_E`=7, `Fwd_rt_D`=1, `FwdData_M`=7 → `PCSrc_D`=1.
- `ID_en`=0 for 3 cycles while `IM` changes → `Instr_D`/`ADD8_D` unchanged. A write to `$0` with `WD_W`=`32'hFFFF_FFFF` → `RD1_D` reads 0.
- Reset asserted mid-branch with GRF `$3`=9 → after the edge `Instr_D`=0, all qualifiers 0, and reading `$3` gives 0.
